// File: rtl/fifo_rd_pkg.sv
// Shared defaults, emit classification and lane-mask helpers for the fifo read-side packer.
package fifo_rd_pkg;

    localparam int unsigned DEF_DATW  = 8;
    localparam int unsigned DEF_PACK  = 4;
    localparam int unsigned DEF_TOUTW = 8;

    localparam int unsigned MAX_PACK  = 16;
    localparam int unsigned MAX_BITS  = 512;

    typedef enum logic [1:0] {
        EMIT_NONE = 2'd0,
        EMIT_FULL = 2'd1,
        EMIT_PART = 2'd2
    } emit_e;

    // Lane-valid mask with the lowest idx lanes set; callers truncate to PACK bits.
    function automatic logic [MAX_PACK-1:0] mask_from_idx(input int unsigned idx);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PACK; i++) begin
            if (i < idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Bit mask keeping lanes below idx; lanes at or above idx are zeroed when ANDed in.
    function automatic logic [MAX_BITS-1:0] lane_bits(input int unsigned idx,
                                                      input int unsigned datw);
        logic [MAX_BITS-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (i < idx * datw) b[i] = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter with clear/enable; flags when the count reaches a nonzero limit.
module fifo_rd_idle_timer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned TOUTW = DEF_TOUTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TOUTW-1:0] timeout_val,
    output logic             timeout_hit
);

    logic [TOUTW-1:0] tcnt_q;
    logic [TOUTW-1:0] tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr) begin
            tcnt_d = '0;
        end else if (en && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + TOUTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign timeout_hit = (timeout_val != '0) && (tcnt_q == timeout_val);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through fifo and packs PACK entries per output word,
// closing partial words on idle timeout or flush with a lane-keep mask.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATW  = DEF_DATW,
    parameter int unsigned PACK  = DEF_PACK,
    parameter int unsigned IDXW  = 2,
    parameter int unsigned TOUTW = DEF_TOUTW
) (
    input  logic                 rclk,
    input  logic                 rst_async_n,
    input  logic                 rst_sync,
    input  logic                 fifo_empty,
    input  logic [DATW-1:0]      fifo_dout,
    output logic                 fifo_re,
    input  logic [TOUTW-1:0]     timeout_val,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATW*PACK-1:0] m_data,
    output logic [PACK-1:0]      m_keep,
    output logic                 m_last,
    output logic                 busy
);

    localparam int unsigned      WORDW    = DATW * PACK;
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(PACK - 1);

    logic [WORDW-1:0] acc_q, acc_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             flush_pend_q, flush_pend_d;
    logic             m_valid_q, m_valid_d;
    logic [WORDW-1:0] m_data_q, m_data_d;
    logic [PACK-1:0]  m_keep_q, m_keep_d;
    logic             m_last_q, m_last_d;

    logic  out_free;
    logic  emit_part;
    logic  pop;
    logic  word_done;
    logic  timeout_hit;
    logic  tmr_clr;
    logic  tmr_en;
    emit_e emit_kind;

    always_comb begin
        out_free  = ~m_valid_q | m_ready;
        emit_part = (flush_pend_q | timeout_hit) & (idx_q != '0) & out_free;
        // Last-lane pop needs a free output slot because it loads the word on the same edge.
        pop       = ~rst_sync & ~fifo_empty & ~emit_part & ((idx_q != IDX_LAST) | out_free);
        word_done = pop & (idx_q == IDX_LAST);
        tmr_clr   = rst_sync | pop | emit_part | (idx_q == '0);
        tmr_en    = ~pop & (idx_q != '0);
    end

    always_comb begin
        emit_kind = EMIT_NONE;
        if (emit_part) begin
            emit_kind = EMIT_PART;
        end else if (word_done) begin
            emit_kind = EMIT_FULL;
        end
    end

    fifo_rd_idle_timer #(
        .TOUTW (TOUTW)
    ) u_idle_timer (
        .clk         (rclk),
        .rst_n       (rst_async_n),
        .clr         (tmr_clr),
        .en          (tmr_en),
        .timeout_val (timeout_val),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        acc_d        = acc_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;

        if (pop) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (idx_q == IDXW'(i)) acc_d[i*DATW +: DATW] = fifo_dout;
            end
            idx_d = idx_q + IDXW'(1);
        end

        if (m_ready) m_valid_d = 1'b0;

        unique case (emit_kind)
            EMIT_PART: begin
                m_data_d  = acc_q & WORDW'(lane_bits(32'(idx_q), DATW));
                m_keep_d  = PACK'(mask_from_idx(32'(idx_q)));
                m_last_d  = 1'b1;
                m_valid_d = 1'b1;
                idx_d     = '0;
            end
            EMIT_FULL: begin
                m_data_d  = acc_d;
                m_keep_d  = '1;
                m_last_d  = flush;
                m_valid_d = 1'b1;
            end
            default: ;
        endcase

        // A flush only survives if there is, or is about to be, a partial word to close.
        if (emit_kind != EMIT_NONE) begin
            flush_pend_d = 1'b0;
        end else if (flush && ((idx_q != '0) || pop)) begin
            flush_pend_d = 1'b1;
        end

        if (rst_sync) begin
            acc_d        = '0;
            idx_d        = '0;
            flush_pend_d = 1'b0;
            m_valid_d    = 1'b0;
            m_data_d     = '0;
            m_keep_d     = '0;
            m_last_d     = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            acc_q        <= '0;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
        end
    end

    assign fifo_re = pop;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign busy    = (idx_q != '0) | m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural fifo and byte-stream model, scenario tasks, random traffic.
module tb_fifo_rd_packer;

    localparam int DATW  = 8;
    localparam int PACK  = 4;
    localparam int IDXW  = 2;
    localparam int TOUTW = 8;

    logic                 rclk = 1'b0;
    logic                 rst_async_n;
    logic                 rst_sync;
    logic                 fifo_empty;
    logic [DATW-1:0]      fifo_dout;
    logic                 fifo_re;
    logic [TOUTW-1:0]     timeout_val;
    logic                 flush;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATW*PACK-1:0] m_data;
    logic [PACK-1:0]      m_keep;
    logic                 m_last;
    logic                 busy;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DATW  (DATW),
        .PACK  (PACK),
        .IDXW  (IDXW),
        .TOUTW (TOUTW)
    ) dut (
        .rclk        (rclk),
        .rst_async_n (rst_async_n),
        .rst_sync    (rst_sync),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_re     (fifo_re),
        .timeout_val (timeout_val),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int underflow = 0;
    int first_valid_edge = -1;
    bit gate = 1'b0;

    byte unsigned src_q[$];
    byte unsigned popped[$];
    byte unsigned pushed[$];
    logic [31:0]  w_data[$];
    logic [3:0]   w_keep[$];
    logic         w_last[$];
    int           w_edge[$];
    int           pop_edge[$];

    // Little-endian packing of n consecutive bytes starting at 'start'.
    function automatic logic [31:0] pack_bytes(input byte unsigned b[$], input int start, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) r = r | (32'(b[start+i]) << (8 * i));
        return r;
    endfunction

    task automatic drive_fifo();
        fifo_empty = gate || (src_q.size() == 0);
        fifo_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    task automatic clear_logs();
        popped.delete();
        w_data.delete();
        w_keep.delete();
        w_last.delete();
        w_edge.delete();
        pop_edge.delete();
        first_valid_edge = -1;
    endtask

    // One clock: sample handshakes mid-cycle, then apply their effects just after the edge.
    task automatic tick();
        bit p, a;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        drive_fifo();
        @(negedge rclk);
        p = fifo_re;
        a = m_valid && m_ready;
        d = m_data;
        k = m_keep;
        l = m_last;
        if (m_valid && first_valid_edge < 0) first_valid_edge = cyc;
        if (fifo_re && fifo_empty) begin
            underflow++;
            $display("FAIL underflow: fifo_re=1 while fifo_empty=1 at edge %0d", cyc + 1);
        end
        @(posedge rclk);
        cyc++;
        #1;
        if (p && src_q.size() != 0) begin
            popped.push_back(src_q.pop_front());
            pop_edge.push_back(cyc);
        end
        if (a) begin
            w_data.push_back(d);
            w_keep.push_back(k);
            w_last.push_back(l);
            w_edge.push_back(cyc);
        end
        drive_fifo();
    endtask

    task automatic sync_reset();
        rst_sync = 1'b1;
        src_q.delete();
        gate    = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        tick();
        rst_sync = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        #2;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++;
        if (m_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", m_data); end
        checks++;
        if (m_keep !== 4'h0) begin failures++; $display("FAIL reset_keep: got %b want 0000", m_keep); end
        checks++;
        if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", m_last); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        #10 rst_async_n = 1'b1;
        @(posedge rclk);
        #1;
        src_q.push_back(8'h5A);
        rst_sync = 1'b1;
        drive_fifo();
        @(negedge rclk);
        if (fifo_re !== 1'b0) begin failures++; $display("FAIL sync_reset_re: got %b want 0", fifo_re); end
        checks++;
        @(posedge rclk);
        #1;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sync_reset_state: valid=%b busy=%b want 0 0", m_valid, busy);
        end
        checks++;
        rst_sync = 1'b0;
        src_q.delete();
        drive_fifo();
        clear_logs();
    endtask

    task automatic test_full_word();
        sync_reset();
        timeout_val = '0;
        m_ready = 1'b1;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 20 && w_data.size() < 1; i++) tick();
        if (w_data.size() !== 1 || popped.size() !== 4) begin
            failures++;
            $display("FAIL full_count: words=%0d pops=%0d want 1 4", w_data.size(), popped.size());
        end
        checks++;
        if (popped.size() == 4) begin
            if (pop_edge[3] - pop_edge[0] !== 3) begin
                failures++; $display("FAIL full_consecutive: span=%0d want 3", pop_edge[3] - pop_edge[0]);
            end
            checks++;
            if (first_valid_edge !== pop_edge[3]) begin
                failures++; $display("FAIL full_latency: valid@%0d want %0d", first_valid_edge, pop_edge[3]);
            end
            checks++;
        end
        if (w_data.size() == 1) begin
            if (w_data[0] !== pack_bytes(popped, 0, 4) || w_data[0] !== 32'h44332211) begin
                failures++; $display("FAIL full_data: got %h want 44332211", w_data[0]);
            end
            checks++;
            if (w_keep[0] !== 4'b1111 || w_last[0] !== 1'b0) begin
                failures++; $display("FAIL full_keep_last: got %b/%b want 1111/0", w_keep[0], w_last[0]);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        sync_reset();
        timeout_val = '0;
        for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
        for (int i = 0; i < 12; i++) tick();
        #1;
        if (popped.size() !== 7) begin
            failures++; $display("FAIL b2b_stall_pops: got %0d want 7", popped.size());
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201 || fifo_re !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_held: valid=%b data=%h re=%b busy=%b want 1 04030201 0 1",
                     m_valid, m_data, fifo_re, busy);
        end
        checks++;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && w_data.size() < 2; i++) tick();
        if (w_data.size() !== 2 || popped.size() !== 8) begin
            failures++;
            $display("FAIL b2b_count: words=%0d pops=%0d want 2 8", w_data.size(), popped.size());
        end
        checks++;
        if (w_data.size() == 2 && popped.size() == 8) begin
            if (w_data[0] !== pack_bytes(popped, 0, 4) || w_data[1] !== pack_bytes(popped, 4, 4)) begin
                failures++;
                $display("FAIL b2b_data: got %h %h want %h %h", w_data[0], w_data[1],
                         pack_bytes(popped, 0, 4), pack_bytes(popped, 4, 4));
            end
            checks++;
            if (w_edge[1] - w_edge[0] !== 1) begin
                failures++; $display("FAIL b2b_gap: got %0d want 1", w_edge[1] - w_edge[0]);
            end
            checks++;
        end
    endtask

    task automatic test_timeout();
        sync_reset();
        timeout_val = 8'd5;
        m_ready = 1'b1;
        src_q = '{8'hAA, 8'hBB};
        for (int i = 0; i < 40 && w_data.size() < 1; i++) tick();
        if (w_data.size() !== 1 || popped.size() !== 2) begin
            failures++;
            $display("FAIL timeout_count: words=%0d pops=%0d want 1 2", w_data.size(), popped.size());
        end
        checks++;
        if (w_data.size() == 1 && popped.size() == 2) begin
            if (first_valid_edge - pop_edge[1] !== 6) begin
                failures++; $display("FAIL timeout_delay: got %0d want 6", first_valid_edge - pop_edge[1]);
            end
            checks++;
            if (w_data[0] !== pack_bytes(popped, 0, 2) || w_keep[0] !== 4'b0011 || w_last[0] !== 1'b1) begin
                failures++;
                $display("FAIL timeout_word: got %h/%b/%b want %h/0011/1", w_data[0], w_keep[0],
                         w_last[0], pack_bytes(popped, 0, 2));
            end
            checks++;
        end
        sync_reset();
        timeout_val = '0;
        m_ready = 1'b1;
        src_q = '{8'h3C, 8'hC3};
        for (int i = 0; i < 300; i++) tick();
        if (w_data.size() !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_disabled: words=%0d busy=%b want 0 1", w_data.size(), busy);
        end
        checks++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10 && w_data.size() < 1; i++) tick();
        if (w_data.size() !== 1 || w_keep[0] !== 4'b0011 || w_data[0] !== 32'h0000C33C) begin
            failures++; $display("FAIL timeout_disabled_flush: words=%0d want 1 (keep 0011 data 0000c33c)", w_data.size());
        end
        checks++;
    endtask

    task automatic test_flush();
        sync_reset();
        timeout_val = '0;
        m_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        if (first_valid_edge !== -1 || w_data.size() !== 0) begin
            failures++; $display("FAIL flush_idle: valid seen at %0d, want never", first_valid_edge);
        end
        checks++;
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 12; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        if (w_data.size() !== 0 || m_valid !== 1'b1 || m_keep !== 4'b1111 || popped.size() !== 7) begin
            failures++;
            $display("FAIL flush_pending: words=%0d valid=%b keep=%b pops=%0d want 0 1 1111 7",
                     w_data.size(), m_valid, m_keep, popped.size());
        end
        checks++;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && w_data.size() < 2; i++) tick();
        if (w_data.size() !== 2) begin
            failures++; $display("FAIL flush_count: words=%0d want 2", w_data.size());
        end
        checks++;
        if (w_data.size() == 2 && popped.size() == 7) begin
            if (w_data[0] !== pack_bytes(popped, 0, 4) || w_last[0] !== 1'b0) begin
                failures++; $display("FAIL flush_first: got %h/%b want %h/0", w_data[0], w_last[0], pack_bytes(popped, 0, 4));
            end
            checks++;
            if (w_data[1] !== pack_bytes(popped, 4, 3) || w_keep[1] !== 4'b0111 || w_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL flush_partial: got %h/%b/%b want %h/0111/1", w_data[1], w_keep[1],
                         w_last[1], pack_bytes(popped, 4, 3));
            end
            checks++;
            if (w_edge[1] - w_edge[0] !== 1) begin
                failures++; $display("FAIL flush_gap: got %0d want 1", w_edge[1] - w_edge[0]);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        byte unsigned outs[$];
        byte unsigned b;
        logic [31:0]  d;
        int           n;
        sync_reset();
        pushed.delete();
        underflow = 0;
        timeout_val = 8'($urandom_range(3, 20));
        for (int c = 0; c < 1000; c++) begin
            if (($urandom % 2 == 0) && src_q.size() < 16) begin
                b = 8'($urandom);
                src_q.push_back(b);
                pushed.push_back(b);
            end
            gate    = ($urandom % 3 == 0);
            m_ready = ($urandom % 4 != 0);
            flush   = ($urandom % 40 == 0);
            tick();
        end
        gate = 1'b0;
        flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 200 && src_q.size() != 0; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        if (underflow !== 0) begin failures++; $display("FAIL random_underflow: got %0d want 0", underflow); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL random_drained: busy=%b want 0", busy); end
        checks++;
        foreach (w_data[i]) begin
            n = 0;
            for (int j = 0; j < PACK; j++) n += int'(w_keep[i][j]);
            d = w_data[i];
            if (n == 0 || w_keep[i] !== 4'((1 << n) - 1) ||
                (n < PACK && (w_last[i] !== 1'b1 || (d >> (8 * n)) !== 32'h0))) begin
                failures++;
                $display("FAIL random_word_shape: word %0d keep=%b last=%b data=%h", i, w_keep[i], w_last[i], d);
            end
            checks++;
            for (int j = 0; j < n; j++) outs.push_back(d[8*j +: 8]);
        end
        if (outs.size() !== pushed.size()) begin
            failures++; $display("FAIL random_length: got %0d bytes want %0d", outs.size(), pushed.size());
        end
        checks++;
        for (int i = 0; i < outs.size() && i < pushed.size(); i++) begin
            if (outs[i] !== pushed[i]) begin
                failures++; $display("FAIL random_byte: index %0d got %h want %h", i, outs[i], pushed[i]);
            end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        byte unsigned fresh[$];
        sync_reset();
        timeout_val = '0;
        for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 10; i++) tick();
        #1;
        if (m_valid !== 1'b1 || popped.size() !== 6) begin
            failures++; $display("FAIL arst_setup: valid=%b pops=%0d want 1 6", m_valid, popped.size());
        end
        checks++;
        rst_async_n = 1'b0;
        #1;
        if (m_valid !== 1'b0 || m_keep !== 4'h0 || m_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: valid=%b keep=%b last=%b busy=%b want 0 0000 0 0",
                     m_valid, m_keep, m_last, busy);
        end
        checks++;
        #1 rst_async_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            fresh.push_back(8'($urandom));
            src_q.push_back(fresh[i]);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20 && w_data.size() < 1; i++) tick();
        if (w_data.size() !== 1 || w_data[0] !== pack_bytes(fresh, 0, 4) || w_keep[0] !== 4'b1111) begin
            failures++;
            $display("FAIL arst_fresh_word: words=%0d data=%h want 1 %h", w_data.size(),
                     (w_data.size() != 0) ? w_data[0] : 32'h0, pack_bytes(fresh, 0, 4));
        end
        checks++;
    endtask

    initial begin
        rst_async_n = 1'b0;
        rst_sync    = 1'b0;
        fifo_empty  = 1'b1;
        fifo_dout   = '0;
        flush       = 1'b0;
        m_ready     = 1'b0;
        timeout_val = '0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the dual-clock fifo, running entirely in the rclk domain. It drains the FIFO's first-word-fall-through read port (empty/dout/re) and packs PACK consecutive DATW-bit entries into one wide word. The wide word is presented on a valid/ready stream. Partial words are emitted on an idle timeout or an explicit flush, with a byte-keep mask, so downstream DMA/SPI-out logic never sees a stalled tail.

Parameters:
DATW, 8, width of one FIFO entry (matches the fifo's FIFO_DATW)
PACK, 4, entries per output word; power of two, 2..16
IDXW, 2, log2(PACK); width of the lane index
TOUTW, 8, width of the idle-timeout counter and timeout_val

Ports:
rclk  in  1  read-domain clock, shared with the fifo read side
rst_async_n  in  1  asynchronous reset, active-low
rst_sync  in  1  synchronous clear, active-high, same effect as reset
fifo_empty  in  1  fifo empty flag
fifo_dout  in  DATW  fifo head entry; valid whenever fifo_empty=0
fifo_re  out  1  pop strobe to the fifo
timeout_val  in  TOUTW  idle cycles before a partial word is emitted; 0 disables the timeout
flush  in  1  single-cycle request to emit the pending partial word
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  DATW*PACK  packed word; lane i = bits [i*DATW +: DATW]
m_keep  out  PACK  lane-valid mask
m_last  out  1  word closed by timeout or flush
busy  out  1  high when idx!=0 or m_valid

Behaviour:
- Reset (async low or rst_sync high): idx=0, acc=0, tcnt=0, flush_pend=0. m_valid=0, m_data=0, m_keep=0, m_last=0. fifo_re=0 during a rst_sync cycle.
- Signal definitions:
  - out_free = ~m_valid | m_ready.
  - emit_part = (flush_pend | timeout_hit) & (idx!=0) & out_free.
  - timeout_hit = (timeout_val!=0) & (tcnt==timeout_val).
- Pop rule (combinational): fifo_re = ~fifo_empty & ~emit_part & ((idx!=PACK-1) | out_free). fifo_re is never high while fifo_empty=1, so the block never underflows the fifo.
- On a pop:
  - acc lane idx <= fifo_dout; lanes are little-endian, so the first entry lands in lane 0.
  - idx <= idx+1, wrapping modulo PACK.
  - tcnt <= 0.
- Full word (pop with idx==PACK-1): on the next edge m_data <= {fifo_dout, acc lanes PACK-2..0}, m_keep=all ones, m_last=0, m_valid=1. idx wraps to 0. Latency is 1 rclk from the final pop to m_valid.
- Partial emit (emit_part): m_data <= acc with lanes >= idx forced to 0, m_keep = (1<<idx)-1, m_last=1, m_valid=1. idx, tcnt and flush_pend are cleared. No pop occurs in that cycle.
- Timer: tcnt increments, saturating at all ones, while idx!=0 and no pop. It is held at 0 while idx==0.
- Flush:
  - flush sets flush_pend only if idx!=0, or if a pop occurs in the same cycle.
  - flush with idx==0 and no pop is dropped; zero-length words are never produced.
  - flush coinciding with a pop that completes the word (idx==PACK-1) yields a full word with m_last=1, and flush_pend is not set.
- Output stage:
  - When m_valid=1 and m_ready=0, m_data, m_keep and m_last hold stable and no new word is loaded.
  - When m_ready=1, m_valid drops unless a new word loads on the same edge (back-to-back allowed).
- Throughput: 1 entry/cycle sustained with m_ready=1. A stall occurs only when idx==PACK-1 and the output is occupied.
- rst_sync mid-word discards the accumulated entries without emitting them. Popped data is not restored to the fifo.

Decomposition:
- Package fifo_rd_pkg holds:
  - default DATW/PACK/TOUTW;
  - the keep-mask function mask_from_idx(idx);
  - the lane-zeroing function.
- One sub-module, fifo_rd_idle_timer: TOUTW saturating counter with clear/enable, and the compare against timeout_val producing timeout_hit.
- Accumulator and output register stay in the top level.

Test Plan:
- Fifo holds 0x11,0x22,0x33,0x44, m_ready=1 -> four consecutive fifo_re pulses; 1 cycle after the 4th pop: m_data=0x44332211, m_keep=4'b1111, m_last=0.
- 8 entries 0x01..0x08 with m_ready held 0 -> first word latched, fifo_re drops with idx=3 (3 entries pending); on m_ready=1 both words 0x04030201 and 0x08070605 delivered back-to-back, no entry lost or duplicated.
- timeout_val=5, 2 entries 0xAA,0xBB then fifo empty -> m_valid exactly 6 cycles after the last pop with m_data=0x0000BBAA, m_keep=4'b0011, m_last=1; with timeout_val=0 no emission ever.
- flush pulse with idx=0 -> no m_valid. flush with idx=3 and m_ready=0 on a previous word -> partial (keep=4'b0111, last=1) emitted on the first cycle m_ready=1.
- fifo_empty toggled randomly for 1000 cycles -> fifo_re never high while fifo_empty=1, and the output byte stream equals the input stream in order.
- rst_async_n low mid-word (idx=2, m_valid=1) -> m_valid, m_keep, m_last, busy go 0 immediately; after release the next 4 pops form a fresh word starting at lane 0.
